// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W     = 16;
    localparam int INSTR_W    = 16;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_pi,
    input  logic             reset_n_pi,
    input  logic             clear_pi,
    input  logic             push_pi,
    input  fetch_entry_t     push_entry_pi,
    input  logic             pop_pi,
    output logic [CNT_W-1:0] count_po,
    output logic             head_valid_po,
    output fetch_entry_t     head_po
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer and occupancy bookkeeping; clear overrides any push or pop
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear_pi) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_pi) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_pi) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_pi, pop_pi})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, zeroed on reset so the head outputs read 0 out of reset
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_pi && !clear_pi) begin
            mem_r[wr_ptr_r] <= push_entry_pi;
        end
    end

    assign count_po      = count_r;
    assign head_valid_po = (count_r != CNT_W'(0));
    assign head_po       = mem_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one outstanding imem read per free FIFO slot, buffers returned
// words with their PC, and pulses pc_advance_po once per accepted word or flush.
module instruction_fetch #(
    parameter int ADDR_W     = fetch_pkg::ADDR_W,
    parameter int INSTR_W    = fetch_pkg::INSTR_W,
    parameter int FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
) (
    input  logic               clk_pi,
    input  logic               reset_n_pi,
    input  logic [ADDR_W-1:0]  pc_pi,
    output logic               pc_advance_po,
    input  logic               flush_pi,
    output logic               imem_req_po,
    output logic [ADDR_W-1:0]  imem_addr_po,
    input  logic               imem_ack_pi,
    input  logic [INSTR_W-1:0] imem_rdata_pi,
    output logic               instr_valid_po,
    output logic [INSTR_W-1:0] instr_po,
    output logic [ADDR_W-1:0]  instr_pc_po,
    input  logic               decode_ready_pi
);

    import fetch_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic              req_r;
    logic              req_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_s;
    logic              head_valid_s;
    fetch_entry_t      head_s;
    fetch_entry_t      push_entry_s;

    // Next-state and request control; a flushed request is still drained by waiting for its ack
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = req_r;
        addr_nxt_s  = addr_r;
        push_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!flush_pi && (count_s < CNT_W'(FIFO_DEPTH))) begin
                    state_nxt_s = REQ;
                    req_nxt_s   = 1'b1;
                    addr_nxt_s  = pc_pi;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (imem_ack_pi) begin
                    state_nxt_s = IDLE;
                    req_nxt_s   = 1'b0;
                    push_s      = ~flush_pi;
                end else if (flush_pi) begin
                    state_nxt_s = DISCARD;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DISCARD: begin
                if (imem_ack_pi) begin
                    state_nxt_s = IDLE;
                    req_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // FSM state and registered imem request/address
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            addr_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= req_nxt_s;
            addr_r  <= addr_nxt_s;
        end
    end

    assign push_entry_s = '{instr: imem_rdata_pi, pc: addr_r};
    assign pop_s        = head_valid_s & decode_ready_pi & ~flush_pi;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pi        (clk_pi),
        .reset_n_pi    (reset_n_pi),
        .clear_pi      (flush_pi),
        .push_pi       (push_s),
        .push_entry_pi (push_entry_s),
        .pop_pi        (pop_s),
        .count_po      (count_s),
        .head_valid_po (head_valid_s),
        .head_po       (head_s)
    );

    // The reset term keeps the PC frozen while the stage is held in reset
    assign pc_advance_po  = reset_n_pi & (flush_pi | ((state_r == REQ) & imem_ack_pi & ~flush_pi));
    assign imem_req_po    = req_r;
    assign imem_addr_po   = addr_r;
    assign instr_valid_po = head_valid_s;
    assign instr_po       = head_s.instr;
    assign instr_pc_po    = head_s.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the fetch stage.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic        clk_pi = 1'b0;
    logic        reset_n_pi;
    logic [15:0] pc_pi;
    logic        pc_advance_po;
    logic        flush_pi;
    logic        imem_req_po;
    logic [15:0] imem_addr_po;
    logic        imem_ack_pi;
    logic [15:0] imem_rdata_pi;
    logic        instr_valid_po;
    logic [15:0] instr_po;
    logic [15:0] instr_pc_po;
    logic        decode_ready_pi;

    instruction_fetch dut (
        .clk_pi          (clk_pi),
        .reset_n_pi      (reset_n_pi),
        .pc_pi           (pc_pi),
        .pc_advance_po   (pc_advance_po),
        .flush_pi        (flush_pi),
        .imem_req_po     (imem_req_po),
        .imem_addr_po    (imem_addr_po),
        .imem_ack_pi     (imem_ack_pi),
        .imem_rdata_pi   (imem_rdata_pi),
        .instr_valid_po  (instr_valid_po),
        .instr_po        (instr_po),
        .instr_pc_po     (instr_pc_po),
        .decode_ready_pi (decode_ready_pi)
    );

    always #5 clk_pi = ~clk_pi;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    // Model: buffered words, the single outstanding read, and the program counter
    ent_t        q[$];
    bit          out_m;
    bit          dead_m;
    logic [15:0] addr_m;
    int          wait_m;
    logic [15:0] pc_m;
    logic [15:0] flush_target;
    int          dly;
    bit          dly_rand;
    bit          dead_seen;
    int          adv_cnt;
    logic [15:0] pop_log[$];
    int          n_cmp;
    int          n_bad;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {1'b0, a[14:0] ^ 15'h1234};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        out_m  = 1'b0;
        dead_m = 1'b0;
        addr_m = 16'h0000;
        wait_m = 0;
        pc_m   = 16'h0000;
    endtask

    task automatic drive(input bit f, input bit r, input bit stray);
        flush_pi        = f;
        decode_ready_pi = r;
        pc_pi           = pc_m;
        if (out_m && wait_m == 0) begin
            imem_ack_pi   = 1'b1;
            imem_rdata_pi = dead_m ? 16'hDEAD : mem_word(addr_m);
        end else if (stray && !out_m) begin
            imem_ack_pi   = 1'b1;
            imem_rdata_pi = 16'($urandom);
        end else begin
            imem_ack_pi   = 1'b0;
            imem_rdata_pi = 16'($urandom);
        end
    endtask

    task automatic model_update(input bit adv);
        bit   was_out;
        bit   was_dead;
        int   sz;
        bit   do_push;
        ent_t e;
        was_out  = out_m;
        was_dead = dead_m;
        sz       = q.size();
        do_push  = 1'b0;
        e.instr  = imem_rdata_pi;
        e.pc     = addr_m;
        if (was_out && imem_ack_pi) begin
            do_push = !was_dead && !flush_pi;
            out_m   = 1'b0;
            dead_m  = 1'b0;
        end else if (was_out) begin
            if (flush_pi) dead_m = 1'b1;
            if (wait_m > 0) wait_m--;
        end
        if (!was_out && !flush_pi && sz < DEPTH) begin
            out_m  = 1'b1;
            dead_m = 1'b0;
            addr_m = pc_pi;
            wait_m = dly_rand ? int'($urandom_range(0, 4)) : dly;
        end
        if (flush_pi) begin
            q.delete();
        end else begin
            if (sz > 0 && decode_ready_pi) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        if (adv) pc_m = flush_pi ? flush_target : pc_m + 16'd2;
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model across the edge
    task automatic step();
        bit exp_adv;
        @(negedge clk_pi);
        exp_adv = flush_pi | (out_m & !dead_m & imem_ack_pi & !flush_pi);
        chk("req", imem_req_po, out_m);
        chk("addr", imem_addr_po, addr_m);
        chk("pc_advance", pc_advance_po, exp_adv);
        chk("valid", instr_valid_po, q.size() > 0);
        if (q.size() > 0) begin
            chk("instr", instr_po, q[0].instr);
            chk("instr_pc", instr_pc_po, q[0].pc);
        end
        if (pc_advance_po) adv_cnt++;
        if (instr_valid_po && decode_ready_pi) pop_log.push_back(instr_pc_po);
        if (instr_valid_po && instr_po == 16'hDEAD) dead_seen = 1'b1;
        model_update(exp_adv);
        @(posedge clk_pi);
        #1;
    endtask

    initial begin
        int adv0;
        int i;
        logic [15:0] a3;
        n_cmp = 0;
        n_bad = 0;
        adv_cnt = 0;
        dead_seen = 1'b0;
        dly = 0;
        dly_rand = 1'b0;
        flush_target = 16'h0000;
        model_reset();
        reset_n_pi = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_pi);
        #1;
        flush_pi = 1'b1;
        #1;
        chk("rst_adv", pc_advance_po, 1'b0);
        chk("rst_req", imem_req_po, 1'b0);
        chk("rst_addr", imem_addr_po, 16'h0000);
        chk("rst_valid", instr_valid_po, 1'b0);
        chk("rst_instr", instr_po, 16'h0000);
        chk("rst_pc", instr_pc_po, 16'h0000);
        flush_pi = 1'b0;
        reset_n_pi = 1'b1;

        // Single-cycle ack, decode always ready: words for 0,2,4 in order
        for (i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            step();
        end
        chk("t1_pulses", adv_cnt, 3);
        chk("t1_pops", pop_log.size(), 3);
        if (pop_log.size() >= 3) begin
            chk("t1_pc0", pop_log[0], 16'h0000);
            chk("t1_pc1", pop_log[1], 16'h0002);
            chk("t1_pc2", pop_log[2], 16'h0004);
        end

        // Decode stalled: FIFO fills, requests and PC advances stop
        for (i = 0; i < 12; i++) begin
            if (i == 6) adv_cnt = 0;
            drive(1'b0, 1'b0, 1'b0);
            step();
        end
        chk("t2_valid", instr_valid_po, 1'b1);
        chk("t2_req_idle", imem_req_po, 1'b0);
        chk("t2_no_adv", adv_cnt, 0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        step();
        chk("t2_reissue", imem_req_po, 1'b1);

        // Slow memory: request held stable for 5 cycles, PC advances only on the ack
        dly = 5;
        for (i = 0; i < 20 && !(out_m && wait_m == 5); i++) begin
            drive(1'b0, 1'b1, 1'b0);
            step();
        end
        chk("t3_reach", out_m && wait_m == 5, 1'b1);
        a3 = addr_m;
        adv0 = adv_cnt;
        for (i = 0; i < 5; i++) begin
            chk("t3_req", imem_req_po, 1'b1);
            chk("t3_addr", imem_addr_po, a3);
            drive(1'b0, 1'b1, 1'b0);
            step();
        end
        chk("t3_noadv", adv_cnt - adv0, 0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("t3_ackadv", adv_cnt - adv0, 1);

        // Flush while waiting: the late 0xDEAD word is dropped, refetch from 0x0040
        dly = 4;
        for (i = 0; i < 20 && !(out_m && wait_m == 4 && !dead_m); i++) begin
            drive(1'b0, 1'b1, 1'b0);
            step();
        end
        chk("t4_reach", out_m && wait_m == 4, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        step();
        flush_target = 16'h0040;
        drive(1'b1, 1'b1, 1'b0);
        step();
        for (i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            step();
        end
        chk("t4_empty", instr_valid_po, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("t4_req", imem_req_po, 1'b1);
        chk("t4_redirect", imem_addr_po, 16'h0040);

        // Flush coinciding with ack and a decode pop: one PC pulse, FIFO empty afterwards
        dly = 2;
        for (i = 0; i < 30 && !(q.size() >= 1 && out_m && !dead_m && wait_m == 0); i++) begin
            drive(1'b0, 1'b0, 1'b0);
            step();
        end
        chk("t5_reach", q.size() >= 1 && out_m && wait_m == 0, 1'b1);
        flush_target = 16'h0080;
        adv0 = adv_cnt;
        drive(1'b1, 1'b1, 1'b0);
        step();
        chk("t5_one_pulse", adv_cnt - adv0, 1);
        chk("t5_empty", instr_valid_po, 1'b0);

        // Asynchronous reset in the middle of a request, late ack afterwards
        dly = 3;
        for (i = 0; i < 30 && !(out_m && wait_m == 3 && q.size() > 0); i++) begin
            drive(1'b0, 1'b0, 1'b0);
            step();
        end
        chk("t6_req_before", imem_req_po, 1'b1);
        chk("t6_valid_before", instr_valid_po, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        reset_n_pi = 1'b0;
        #1;
        chk("t6_req_async", imem_req_po, 1'b0);
        chk("t6_valid_async", instr_valid_po, 1'b0);
        chk("t6_adv_async", pc_advance_po, 1'b0);
        model_reset();
        @(posedge clk_pi);
        #1;
        reset_n_pi = 1'b1;
        adv0 = adv_cnt;
        drive(1'b0, 1'b1, 1'b1);
        step();
        chk("t6_late_ack", adv_cnt - adv0, 0);
        chk("t6_valid_after", instr_valid_po, 1'b0);

        // Randomized traffic: random latency, flushes, stalls and stray acks
        dly_rand = 1'b1;
        for (i = 0; i < 3000; i++) begin
            bit f;
            f = ($urandom_range(0, 15) == 0);
            if (f) flush_target = 16'($urandom) & 16'hFFFE;
            drive(f, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            step();
        end
        chk("dead_never_seen", dead_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
